// File: rtl/rvfpm_issue_ctrl.sv
// rvfpm_issue_ctrl: in-order CV-X-IF issue scheduler feeding the rvfpm core.
// Optional 16-bit perf counters are enabled by defining RVFPM_ISSUE_PERF_EN.
`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif
`ifndef X_NUM_RS
`define X_NUM_RS 2
`endif
`ifndef X_RFR_WIDTH
`define X_RFR_WIDTH 32
`endif

package rvfpm_xif_pkg;
    localparam int XID  = `X_ID_WIDTH;
    localparam int XNRS = `X_NUM_RS;
    localparam int XRFR = `X_RFR_WIDTH;

    typedef struct packed {
        logic [31:0]                instr;
        logic [1:0]                 mode;
        logic [XID-1:0]             id;
        logic [XNRS-1:0][XRFR-1:0]  rs;
        logic [XNRS-1:0]            rs_valid;
        logic [5:0]                 ecs;
        logic                       ecs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic ecswrite;
        logic exc;
    } x_issue_resp_t;
endpackage

module rvfpm_issue_ctrl
    import rvfpm_xif_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  x_issue_req_t             issue_req,
    output x_issue_resp_t            issue_resp,
    input  logic                     commit_valid,
    input  logic [XID-1:0]           commit_id,
    input  logic                     commit_kill,
    output logic                     fpu_valid,
    input  logic                     fpu_ready,
    output logic [31:0]              fpu_instr,
    output logic [1:0]               fpu_mode,
    output logic [XID-1:0]           fpu_id,
    output logic [XNRS*XRFR-1:0]     fpu_rs,
    output logic [$clog2(DEPTH):0]   count
`ifdef RVFPM_ISSUE_PERF_EN
    ,
    output logic [15:0]              perf_accepted,
    output logic [15:0]              perf_killed,
    output logic [15:0]              perf_dispatched
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = XNRS * XRFR;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] cmt_q, cmt_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];
    logic [1:0]      mode_q [DEPTH];
    logic [1:0]      mode_d [DEPTH];
    logic [XID-1:0]  id_q [DEPTH];
    logic [XID-1:0]  id_d [DEPTH];
    logic [RW-1:0]   rs_q [DEPTH];
    logic [RW-1:0]   rs_d [DEPTH];

    x_issue_resp_t   dec;
    logic [6:0]      opc;
    logic [4:0]      f5;
    logic            push;
    logic            pop_kill;
    logic            pop_disp;
    logic            hit;
    logic [PW-1:0]   hit_idx;
    logic [PW-1:0]   idx;
    logic            unused_req;

    // Fields the FPU path does not consume.
    assign unused_req = ^{issue_req.rs_valid, issue_req.ecs,
                          issue_req.ecs_valid};

    // Opcode decode: FP loads/stores, fused multiply-adds and OP-FP.
    always_comb begin
        dec = '0;
        opc = issue_req.instr[6:0];
        f5  = issue_req.instr[31:27];
        case (opc)
            7'b0000111, 7'b0100111: begin
                dec.accept    = 1'b1;
                dec.loadstore = 1'b1;
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                dec.accept = 1'b1;
            end
            7'b1010011: begin
                dec.accept    = 1'b1;
                dec.writeback = (f5 == 5'b10100) || (f5 == 5'b11000) ||
                                (f5 == 5'b11100);
            end
            default: ;
        endcase
    end

    assign issue_resp  = dec;
    assign issue_ready = (count_q < CW'(DEPTH));
    assign count       = count_q;

    assign fpu_valid = valid_q[head_q] & cmt_q[head_q];
    assign fpu_instr = instr_q[head_q];
    assign fpu_mode  = mode_q[head_q];
    assign fpu_id    = id_q[head_q];
    assign fpu_rs    = rs_q[head_q];

    assign push     = issue_valid & issue_ready & dec.accept;
    assign pop_kill = valid_q[head_q] & kill_q[head_q];
    assign pop_disp = fpu_valid & fpu_ready;

    // Oldest pending entry whose id matches the commit strobe.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (!hit && valid_q[idx] && !cmt_q[idx] && !kill_q[idx] &&
                id_q[idx] == commit_id) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    // Queue next state: pop at head, commit/kill update, push at tail.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        cmt_d   = cmt_q;
        kill_d  = kill_q;
        instr_d = instr_q;
        mode_d  = mode_q;
        id_d    = id_q;
        rs_d    = rs_q;

        if (pop_kill || pop_disp) begin
            valid_d[head_q] = 1'b0;
            cmt_d[head_q]   = 1'b0;
            kill_d[head_q]  = 1'b0;
            head_d          = head_q + PW'(1);
        end

        if (commit_valid && hit) begin
            if (commit_kill) begin
                kill_d[hit_idx] = 1'b1;
            end else begin
                cmt_d[hit_idx] = 1'b1;
            end
        end

        if (push) begin
            valid_d[tail_q] = 1'b1;
            cmt_d[tail_q]   = 1'b0;
            kill_d[tail_q]  = 1'b0;
            instr_d[tail_q] = issue_req.instr;
            mode_d[tail_q]  = issue_req.mode;
            id_d[tail_q]    = issue_req.id;
            rs_d[tail_q]    = issue_req.rs;
            tail_d          = tail_q + PW'(1);
            if (commit_valid && !hit && commit_id == issue_req.id) begin
                if (commit_kill) begin
                    kill_d[tail_q] = 1'b1;
                end else begin
                    cmt_d[tail_q] = 1'b1;
                end
            end
        end

        case ({push, pop_kill | pop_disp})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            cmt_q   <= '0;
            kill_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                mode_q[i]  <= '0;
                id_q[i]    <= '0;
                rs_q[i]    <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            cmt_q   <= cmt_d;
            kill_q  <= kill_d;
            instr_q <= instr_d;
            mode_q  <= mode_d;
            id_q    <= id_d;
            rs_q    <= rs_d;
        end
    end

`ifdef RVFPM_ISSUE_PERF_EN
    logic [15:0] pacc_q, pacc_d;
    logic [15:0] pkil_q, pkil_d;
    logic [15:0] pdis_q, pdis_d;

    // Saturating event counters.
    always_comb begin
        pacc_d = pacc_q;
        pkil_d = pkil_q;
        pdis_d = pdis_q;
        if (push && pacc_q != 16'hFFFF) pacc_d = pacc_q + 16'd1;
        if (pop_kill && pkil_q != 16'hFFFF) pkil_d = pkil_q + 16'd1;
        if (pop_disp && pdis_q != 16'hFFFF) pdis_d = pdis_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pacc_q <= '0;
            pkil_q <= '0;
            pdis_q <= '0;
        end else begin
            pacc_q <= pacc_d;
            pkil_q <= pkil_d;
            pdis_q <= pdis_d;
        end
    end

    assign perf_accepted   = pacc_q;
    assign perf_killed     = pkil_q;
    assign perf_dispatched = pdis_q;
`endif

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// tb_rvfpm_issue_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based model of the issue scheduler.
module tb_rvfpm_issue_ctrl;
    import rvfpm_xif_pkg::*;

    localparam int DEPTH = 4;
    localparam int RW = XNRS * XRFR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic issue_valid;
    logic issue_ready;
    x_issue_req_t issue_req;
    x_issue_resp_t issue_resp;
    logic commit_valid;
    logic [XID-1:0] commit_id;
    logic commit_kill;
    logic fpu_valid;
    logic fpu_ready;
    logic [31:0] fpu_instr;
    logic [1:0] fpu_mode;
    logic [XID-1:0] fpu_id;
    logic [RW-1:0] fpu_rs;
    logic [$clog2(DEPTH):0] count;
`ifdef RVFPM_ISSUE_PERF_EN
    logic [15:0] perf_accepted, perf_killed, perf_dispatched;
    int m_pa, m_pk, m_pd;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [1:0] mode;
        logic [XID-1:0] id;
        logic [RW-1:0] rs;
        int st;
    } ent_t;
    ent_t mq[$];

    rvfpm_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_req(issue_req), .issue_resp(issue_resp),
        .commit_valid(commit_valid), .commit_id(commit_id),
        .commit_kill(commit_kill),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
        .fpu_instr(fpu_instr), .fpu_mode(fpu_mode),
        .fpu_id(fpu_id), .fpu_rs(fpu_rs), .count(count)
`ifdef RVFPM_ISSUE_PERF_EN
        , .perf_accepted(perf_accepted), .perf_killed(perf_killed),
        .perf_dispatched(perf_dispatched)
`endif
    );

    always #5 clk = ~clk;

    function automatic x_issue_resp_t ref_dec(input logic [31:0] ins);
        x_issue_resp_t r;
        logic [6:0] op;
        logic [4:0] fn;
        r = '0;
        op = ins[6:0];
        fn = ins[31:27];
        if (op inside {7'b0000111, 7'b0100111, 7'b1000011, 7'b1000111,
                       7'b1001011, 7'b1001111, 7'b1010011})
            r.accept = 1'b1;
        if (op inside {7'b0000111, 7'b0100111}) r.loadstore = 1'b1;
        if (op == 7'b1010011 && fn inside {5'b10100, 5'b11000, 5'b11100})
            r.writeback = 1'b1;
        return r;
    endfunction

    task automatic drv(input logic iv, input logic [31:0] ins,
                       input logic [XID-1:0] id, input logic cv,
                       input logic [XID-1:0] cid, input logic ck,
                       input logic fr);
        issue_valid = iv;
        issue_req = '0;
        issue_req.instr = ins;
        issue_req.mode = ins[13:12];
        issue_req.id = id;
        issue_req.rs = {ins ^ 32'hA5A5_0000, 28'h0, id};
        commit_valid = cv;
        commit_id = cid;
        commit_kill = ck;
        fpu_ready = fr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drv(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        drv(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (count !== 0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", issue_ready); end
        n_cmp++; if (fpu_valid !== 1'b0) begin n_err++; $display("FAIL reset_fpu_valid got %b want 0", fpu_valid); end
        n_cmp++; if ({fpu_instr, fpu_mode, fpu_id, fpu_rs} !== '0) begin n_err++; $display("FAIL reset_fpu_fields got %h/%h/%h/%h want 0", fpu_instr, fpu_mode, fpu_id, fpu_rs); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fadd();
        drv(1, 32'h0020_8053, 1, 1, 1, 0, 1);
        #1;
        n_cmp++; if (issue_resp.accept !== 1'b1 || issue_resp.writeback !== 1'b0) begin n_err++; $display("FAIL fadd_resp got %b want 1000000", issue_resp); end
        n_cmp++; if (fpu_valid !== 1'b0) begin n_err++; $display("FAIL fadd_valid_early got %b want 0", fpu_valid); end
        step();
        drv(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (fpu_valid !== 1'b1 || fpu_id !== 1 || fpu_instr !== 32'h0020_8053) begin n_err++; $display("FAIL fadd_dispatch got v=%b id=%0d instr=%h want 1/1/00208053", fpu_valid, fpu_id, fpu_instr); end
        n_cmp++; if (count !== 1) begin n_err++; $display("FAIL fadd_count1 got %0d want 1", count); end
        step();
        #1;
        n_cmp++; if (count !== 0 || fpu_valid !== 1'b0) begin n_err++; $display("FAIL fadd_drain got count=%0d v=%b want 0/0", count, fpu_valid); end
    endtask

    task automatic test_reject();
        drv(1, 32'h0000_0033, 7, 0, 0, 0, 1);
        #1;
        n_cmp++; if (issue_resp !== '0) begin n_err++; $display("FAIL reject_resp got %b want 0000000", issue_resp); end
        step();
        drv(1, 32'hC000_0053, 2, 1, 2, 1, 1);
        #1;
        n_cmp++; if (count !== 0) begin n_err++; $display("FAIL reject_count got %0d want 0", count); end
        n_cmp++; if (issue_resp !== 7'b1100000) begin n_err++; $display("FAIL fcvt_resp got %b want 1100000", issue_resp); end
        step();
        drv(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (count !== 1 || fpu_valid !== 1'b0) begin n_err++; $display("FAIL killed_head got count=%0d v=%b want 1/0", count, fpu_valid); end
        step();
        #1;
        n_cmp++; if (count !== 0) begin n_err++; $display("FAIL killed_pop got %0d want 0", count); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 32'h0000_2007, XID'(i), 0, 0, 0, 1);
            #1;
            n_cmp++; if (issue_resp !== 7'b1000100 || issue_ready !== 1'b1) begin n_err++; $display("FAIL full_issue%0d got resp=%b rdy=%b want 1000100/1", i, issue_resp, issue_ready); end
            step();
        end
        drv(1, 32'h0020_8053, 9, 0, 0, 0, 1);
        #1;
        n_cmp++; if (count !== 4 || issue_ready !== 1'b0 || fpu_valid !== 1'b0) begin n_err++; $display("FAIL full_state got count=%0d rdy=%b v=%b want 4/0/0", count, issue_ready, fpu_valid); end
        step();
        drv(0, 0, 0, 1, 0, 0, 1);
        #1;
        n_cmp++; if (count !== 4) begin n_err++; $display("FAIL full_no_push got %0d want 4", count); end
        step();
        drv(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (fpu_valid !== 1'b1 || fpu_id !== 0 || issue_ready !== 1'b0) begin n_err++; $display("FAIL full_dispatch got v=%b id=%0d rdy=%b want 1/0/0", fpu_valid, fpu_id, issue_ready); end
        step();
        #1;
        n_cmp++; if (count !== 3 || issue_ready !== 1'b1 || fpu_valid !== 1'b0) begin n_err++; $display("FAIL full_after got count=%0d rdy=%b v=%b want 3/1/0", count, issue_ready, fpu_valid); end
    endtask

    task automatic test_kill();
        apply_reset();
        drv(1, 32'h0020_8053, 5, 0, 0, 0, 1);
        step();
        drv(1, 32'h1020_8053, 6, 0, 0, 0, 1);
        step();
        drv(0, 0, 0, 1, 5, 1, 1);
        step();
        drv(0, 0, 0, 1, 6, 0, 1);
        #1;
        n_cmp++; if (fpu_valid !== 1'b0 || count !== 2) begin n_err++; $display("FAIL kill_head got v=%b count=%0d want 0/2", fpu_valid, count); end
        step();
        drv(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (fpu_valid !== 1'b1 || fpu_id !== 6 || fpu_instr !== 32'h1020_8053) begin n_err++; $display("FAIL kill_next got v=%b id=%0d instr=%h want 1/6/10208053", fpu_valid, fpu_id, fpu_instr); end
        step();
        #1;
        n_cmp++; if (count !== 0) begin n_err++; $display("FAIL kill_drain got %0d want 0", count); end
`ifdef RVFPM_ISSUE_PERF_EN
        n_cmp++; if (perf_accepted !== 2 || perf_killed !== 1 || perf_dispatched !== 1) begin n_err++; $display("FAIL kill_perf got %0d/%0d/%0d want 2/1/1", perf_accepted, perf_killed, perf_dispatched); end
`endif
    endtask

    task automatic test_stall();
        logic [RW-1:0] rs0;
        apply_reset();
        drv(1, 32'h1820_8053, 3, 1, 3, 0, 0);
        rs0 = issue_req.rs;
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (fpu_valid !== 1'b1 || fpu_id !== 3 || fpu_instr !== 32'h1820_8053 || fpu_rs !== rs0 || count !== 1) begin n_err++; $display("FAIL stall%0d got v=%b id=%0d instr=%h count=%0d want 1/3/18208053/1", k, fpu_valid, fpu_id, fpu_instr, count); end
            step();
        end
        fpu_ready = 1'b1;
        #1;
        n_cmp++; if (fpu_valid !== 1'b1) begin n_err++; $display("FAIL stall_release got %b want 1", fpu_valid); end
        step();
        #1;
        n_cmp++; if (count !== 0 || fpu_valid !== 1'b0) begin n_err++; $display("FAIL stall_pop got count=%0d v=%b want 0/0", count, fpu_valid); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drv(1, 32'h0020_8053, 1, 1, 1, 0, 0);
        step();
        drv(1, 32'h0020_8053, 2, 0, 0, 0, 0);
        step();
        drv(1, 32'h0020_8053, 3, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (count !== 3 || fpu_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got count=%0d v=%b want 3/1", count, fpu_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (count !== 0 || fpu_valid !== 1'b0 || issue_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset got count=%0d v=%b rdy=%b want 0/0/1", count, fpu_valid, issue_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drv(0, 0, 0, 1, 2, 0, 1);
        step();
        drv(0, 0, 0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (count !== 0 || fpu_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_commit got count=%0d v=%b want 0/0", count, fpu_valid); end
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        logic [4:0] wbf [3];
        logic [31:0] ins;
        logic iv, cv, ck, fr, hit, acc;
        logic [XID-1:0] id, cid;
        x_issue_resp_t er;
        ent_t e;
        int exp_cnt;
        logic exp_fv;
        ops = '{7'b0000111, 7'b0100111, 7'b1000011, 7'b1000111, 7'b1001011,
                7'b1001111, 7'b1010011, 7'b1010011, 7'b0110011};
        wbf = '{5'b10100, 5'b11000, 5'b11100};
        apply_reset();
        mq.delete();
`ifdef RVFPM_ISSUE_PERF_EN
        m_pa = 0; m_pk = 0; m_pd = 0;
`endif
        for (int c = 0; c < 600; c++) begin
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) ins[31:27] = wbf[$urandom_range(0, 2)];
            iv = ($urandom_range(0, 1) == 1);
            id = XID'($urandom_range(0, 3));
            cv = ($urandom_range(0, 9) < 4);
            cid = XID'($urandom_range(0, 3));
            ck = ($urandom_range(0, 9) < 3);
            fr = ($urandom_range(0, 9) < 7);
            drv(iv, ins, id, cv, cid, ck, fr);
            issue_req.rs = {$urandom(), $urandom()};
            #1;
            er = ref_dec(ins);
            exp_cnt = mq.size();
            exp_fv = (mq.size() > 0) && (mq[0].st == 1);
            n_cmp++; if (issue_resp !== er) begin n_err++; $display("FAIL rnd_resp c=%0d got %b want %b", c, issue_resp, er); end
            n_cmp++; if (issue_ready !== (exp_cnt < DEPTH) || count !== exp_cnt) begin n_err++; $display("FAIL rnd_occ c=%0d got rdy=%b count=%0d want count=%0d", c, issue_ready, count, exp_cnt); end
            n_cmp++; if (fpu_valid !== exp_fv) begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, fpu_valid, exp_fv); end
            if (exp_fv) begin
                n_cmp++; if (fpu_instr !== mq[0].instr || fpu_mode !== mq[0].mode || fpu_id !== mq[0].id || fpu_rs !== mq[0].rs) begin n_err++; $display("FAIL rnd_head c=%0d got %h/%0d/%0d want %h/%0d/%0d", c, fpu_instr, fpu_mode, fpu_id, mq[0].instr, mq[0].mode, mq[0].id); end
            end
            acc = iv && (mq.size() < DEPTH) && er.accept;
            if (mq.size() > 0) begin
                if (mq[0].st == 2) begin
                    void'(mq.pop_front());
`ifdef RVFPM_ISSUE_PERF_EN
                    m_pk++;
`endif
                end else if (mq[0].st == 1 && fr) begin
                    void'(mq.pop_front());
`ifdef RVFPM_ISSUE_PERF_EN
                    m_pd++;
`endif
                end
            end
            hit = 1'b0;
            if (cv) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (!hit && mq[j].st == 0 && mq[j].id == cid) begin
                        mq[j].st = ck ? 2 : 1;
                        hit = 1'b1;
                    end
                end
            end
            if (acc) begin
                e.instr = ins;
                e.mode = issue_req.mode;
                e.id = id;
                e.rs = issue_req.rs;
                e.st = (cv && !hit && cid == id) ? (ck ? 2 : 1) : 0;
                mq.push_back(e);
`ifdef RVFPM_ISSUE_PERF_EN
                m_pa++;
`endif
            end
            step();
        end
`ifdef RVFPM_ISSUE_PERF_EN
        #1;
        n_cmp++; if (perf_accepted !== 16'(m_pa) || perf_killed !== 16'(m_pk) || perf_dispatched !== 16'(m_pd)) begin n_err++; $display("FAIL rnd_perf got %0d/%0d/%0d want %0d/%0d/%0d", perf_accepted, perf_killed, perf_dispatched, m_pa, m_pk, m_pd); end
`endif
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_reject();
        test_full();
        test_kill();
        test_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rvfpm_issue_ctrl.md
# rvfpm_issue_ctrl

In-order issue scheduler between the CV-X-IF issue/commit interface and the rvfpm execution core. It decodes each offered instruction and answers accept/writeback/loadstore in the same cycle. Accepted instructions are buffered in a DEPTH-entry queue, where each entry waits for its commit or kill. Committed entries are dispatched oldest-first to the FPU over a valid/ready handshake; killed entries are dropped without dispatch.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2.
- Widths come from the `X_ID_WIDTH`, `X_NUM_RS` and `X_RFR_WIDTH` defines.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- issue_valid  in  1  issue request offered.
- issue_ready  out  1  controller can take a request.
- issue_req  in  x_issue_req_t  instr, mode, id, rs, rs_valid, ecs, ecs_valid.
- issue_resp  out  x_issue_resp_t  decode result; meaningful only while issue_valid=1.
- commit_valid  in  1  commit/kill strobe.
- commit_id  in  X_ID_WIDTH  target id.
- commit_kill  in  1  1 = kill, 0 = commit.
- fpu_valid  out  1  dispatch offered.
- fpu_ready  in  1  FPU takes dispatch.
- fpu_instr  out  32  head instruction.
- fpu_mode  out  2  head mode.
- fpu_id  out  X_ID_WIDTH  head id.
- fpu_rs  out  X_NUM_RS×X_RFR_WIDTH  head operands.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
Decode (combinational, from issue_req.instr[6:0]):
- accept=1 for these opcodes: 0000111 LOAD-FP, 0100111 STORE-FP, 1000011, 1000111, 1001011, 1001111, 1010011 OP-FP.
- loadstore=1 for LOAD-FP and STORE-FP.
- writeback=1 for OP-FP with instr[31:27] ∈ {10100, 11000, 11100}, i.e. integer-rd results.
- dualwrite, dualread, ecswrite and exc are always 0.
- All resp fields are 0 when accept=0.

Issue:
- issue_ready = (count < DEPTH).
- A handshake occurs when issue_valid & issue_ready.
- If accept=1, the entry {instr, mode, id, rs, committed=0, killed=0} is written at the tail.
- If accept=0, the handshake completes and nothing is enqueued.

Commit:
- When commit_valid=1, the oldest valid entry with id==commit_id and committed=killed=0 is updated.
- commit_kill=0 sets committed; commit_kill=1 sets killed.
- A commit that matches no entry is ignored.
- A commit in the same cycle as an issue handshake with the same id applies to the newly written entry, but only if no older entry matches.

Head processing, in priority order:
- Head killed: pop on this edge; fpu_valid=0 this cycle.
- Head committed: fpu_valid=1 with the head fields. Pop on fpu_valid & fpu_ready.
- Head not yet resolved, or queue empty: fpu_valid=0.

Queue behaviour:
- A push and a pop in the same cycle leave count unchanged. This is allowed when full, provided the pop occurs.
- issue_ready is computed before the pop, so a full queue still reports ready=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Dispatch rules:
- Once fpu_valid rises, fpu_instr, fpu_mode, fpu_id and fpu_rs stay stable until the handshake.
- fpu_valid never drops without a handshake, because a kill can no longer target a committed entry.

## Timing
- issue_resp and issue_ready are combinational, same cycle as issue_valid.
- Minimum latency: issue and commit in cycle N → fpu_valid=1 in cycle N+1.
- Minimum latency with a later commit: commit in cycle M → fpu_valid=1 in cycle M+1 if the entry is at the head.
- A killed entry at the head occupies exactly one cycle before it is popped.
- Back-to-back dispatch: one per cycle while fpu_ready=1 and consecutive heads are committed.
- Reset values: pointers=0, count=0, all entry valid/committed/killed bits=0, issue_ready=1, fpu_valid=0, fpu_instr/mode/id/rs=0.
- Reset asserted mid-operation discards all entries immediately, including any in-flight dispatch.

## Configuration
- RVFPM_ISSUE_PERF_EN defined: adds outputs perf_accepted, perf_killed and perf_dispatched, each 16 bits.
  - perf_accepted counts accepted issue handshakes.
  - perf_killed counts kill pops.
  - perf_dispatched counts FPU handshakes.
  - Counters saturate at 0xFFFF and reset to 0.
- RVFPM_ISSUE_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Issue OP-FP fadd.s (0x00208053, id=1) with a commit of id=1 in the same cycle, fpu_ready=1 → accept=1, writeback=0; next cycle fpu_valid=1, fpu_id=1, fpu_instr=0x00208053; count returns to 0.
- Issue opcode 0110011 (integer ADD) → accept=0, all resp fields 0, count stays 0.
- Issue 4 accepted instructions (ids 0–3) with no commits → count=4, issue_ready=0. Commit id 0 with fpu_ready=1 → one dispatch, issue_ready=1.
- Issue ids 5, 6; kill 5; commit 6 → id 5 is dropped in one cycle with no fpu_valid, then fpu_id=6 is dispatched; perf_killed=1 when RVFPM_ISSUE_PERF_EN is defined.
- Hold fpu_ready=0 for 3 cycles with a committed head → fpu_valid stays 1 and fpu_* stay stable; the pop happens only on the cycle fpu_ready=1.
- Reset with 3 entries queued and fpu_valid=1 → count=0, fpu_valid=0 and issue_ready=1 immediately; a later commit of an old id is ignored.
